posit_mult_result_buffer: RTL and testbench

- Downstream stage of the 16-bit posit multiplier.
- Captures each multiplier result (r, inf, zero) on its done pulse into a small first-word-fall-through FIFO.
- Presents results to the consumer over valid/ready.
- The multiplier cannot stall, so the block also tracks in-flight operations and gives the upstream issuer a credit signal (issue_ok). A result therefore always has a FIFO slot when it emerges.

---
 rtl/posit_mult_result_buffer.sv | 137 +++++++++++++
 tb/tb_posit_mult_result_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : posit_mult_result_buffer
//  Description : Result buffer behind the 16-bit posit multiplier.
//                Each result is captured into a small first-word-fall-through
//                FIFO on the multiplier's done pulse. The FIFO presents results
//                to the consumer over a valid/ready handshake.
//                The multiplier cannot stall, so this block also counts
//                operations in flight. It returns a credit (issue_ok) to the
//                issuer so that every result is guaranteed a FIFO slot.
//
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                mul_start       - one operation issued to the multiplier
//                mul_r/inf/zero  - multiplier result fields
//                mul_done        - multiplier result valid this cycle
//                issue_ok        - issuer may assert mul_start this cycle
//                out_data/inf/zero, out_valid, out_ready - consumer side
//                count           - FIFO occupancy
//                err             - sticky error (overflow, stray done,
//                                  issue without credit)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_mult_result_buffer #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_start,
    input  logic [N-1:0]     mul_r,
    input  logic             mul_inf,
    input  logic             mul_zero,
    input  logic             mul_done,
    output logic             issue_ok,
    output logic [N-1:0]     out_data,
    output logic             out_inf,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Entry layout: {inf, zero, r}
    logic [N+1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_inflight;
    logic             r_err;

    logic             w_full;
    logic             w_read;
    logic             w_write;
    logic             w_overflow;
    logic             w_underflow;
    logic             w_credit_viol;
    logic [CNT_W:0]   w_outstanding;
    logic [N+1:0]     w_head;

    assign w_full    = (r_count == c_depth);
    assign out_valid = (r_count != '0);
    assign w_read    = out_valid & out_ready;

    // A read in the same cycle frees the head slot, so a write at full is still
    // accepted. In that case wr_ptr == rd_ptr. The head is read out before the
    // edge, and the new word overwrites the slot at the edge.
    assign w_write       = mul_done & (~w_full | w_read);
    assign w_overflow    = mul_done & w_full & ~w_read;
    assign w_underflow   = mul_done & (r_inflight == '0);

    // The credit is derived only from flops. The issuer therefore never sees a
    // combinational path from its own start pulse.
    assign w_outstanding = {1'b0, r_count} + {1'b0, r_inflight};
    assign issue_ok      = (w_outstanding < {1'b0, c_depth});
    assign w_credit_viol = mul_start & ~issue_ok;

    // The outputs are forced to zero while the FIFO is empty. Stale storage is
    // therefore never visible on the outputs.
    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
    assign {out_inf, out_zero, out_data} = w_head;

    assign count = r_count;
    assign err   = r_err;

    // Storage has no reset. Its contents are only observed through the
    // pointers and the occupancy count, which are reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {mul_inf, mul_zero, mul_r};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_write, w_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // A stray done holds the counter at zero instead of letting it
            // wrap. Issues without credit saturate rather than wrap.
            if (mul_start && !mul_done) begin
                if (r_inflight != c_cnt_max) begin
                    r_inflight <= r_inflight + 1'b1;
                end
            end else if (!mul_start && mul_done && (r_inflight != '0)) begin
                r_inflight <= r_inflight - 1'b1;
            end

            r_err <= r_err | w_overflow | w_underflow | w_credit_viol;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_mult_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_mult_result_buffer
//  Description : Self-checking bench for posit_mult_result_buffer.
//                Every result that the FIFO should accept is pushed to a
//                scoreboard queue. The queue is compared against the consumer
//                side whenever a transfer takes place.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_mult_result_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             mul_start;
    logic [N-1:0]     mul_r;
    logic             mul_inf;
    logic             mul_zero;
    logic             mul_done;
    logic             issue_ok;
    logic [N-1:0]     out_data;
    logic             out_inf;
    logic             out_zero;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             err;

    posit_mult_result_buffer #(
        .N     (N),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mul_start (mul_start),
        .mul_r     (mul_r),
        .mul_inf   (mul_inf),
        .mul_zero  (mul_zero),
        .mul_done  (mul_done),
        .issue_ok  (issue_ok),
        .out_data  (out_data),
        .out_inf   (out_inf),
        .out_zero  (out_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] in_r;
        logic         in_inf;
        logic         in_zero;
        logic [N-1:0] exp_data;
        logic         exp_inf;
        logic         exp_zero;
    } vec_t;

    int               n_tests;
    int               n_fail;
    int               n_rx;
    logic [N+1:0]     sb [$];
    logic             hold_pending;
    logic [N+1:0]     hold_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle. The consumer side is observed at the falling edge.
    // Control then returns to the caller just after the next rising edge.
    task automatic tick();
        logic [N+1:0] exp_w;
        @(negedge clk);
        if (hold_pending) begin
            check("hold_stable", 32'({out_inf, out_zero, out_data}), 32'(hold_word));
        end
        hold_pending = out_valid && !out_ready;
        hold_word    = {out_inf, out_zero, out_data};
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underrun", 32'(1), 32'(0));
            end else begin
                exp_w = sb.pop_front();
                check("sb_data", 32'({out_inf, out_zero, out_data}), 32'(exp_w));
                n_rx++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_done(input logic [N-1:0] r, input logic inf, input logic zero,
                              input logic accept);
        mul_done = 1'b1;
        mul_r    = r;
        mul_inf  = inf;
        mul_zero = zero;
        if (accept) sb.push_back({inf, zero, r});
    endtask

    task automatic clear_done();
        mul_done = 1'b0;
        mul_r    = '0;
        mul_inf  = 1'b0;
        mul_zero = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int k = 0; k < budget && out_valid; k++) tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    vec_t tbl [4];

    initial begin
        int           pend [$];
        int           issued;
        int           cyc;
        logic [N-1:0] rr;

        tbl[0] = '{16'h4000, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0};
        tbl[1] = '{16'h5000, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0};
        tbl[3] = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};

        n_tests      = 0;
        n_fail       = 0;
        n_rx         = 0;
        hold_pending = 1'b0;
        hold_word    = '0;
        rst          = 1'b1;
        mul_start    = 1'b0;
        out_ready    = 1'b0;
        clear_done();

        // ---- reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_count",     32'(count),     32'(0));
        check("rst_issue_ok",  32'(issue_ok),  32'(1));
        check("rst_err",       32'(err),       32'(0));
        check("rst_out_data",  32'(out_data),  32'(16'h0000));

        // ---- single operation with a 6-cycle multiplier latency
        out_ready = 1'b1;
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        check("single_issue_ok", 32'(issue_ok), 32'(1));
        repeat (5) tick();
        drive_done(16'h4800, 1'b0, 1'b0, 1'b1);
        tick();
        clear_done();
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_data",  32'(out_data),  32'(16'h4800));
        tick();
        check("single_count", 32'(count),    32'(0));
        check("single_ok",    32'(issue_ok), 32'(1));
        out_ready = 1'b0;

        // ---- credit fill and in-order drain, table driven
        for (int i = 0; i < 4; i++) begin
            mul_start = 1'b1;
            tick();
            check("fill_issue_ok", 32'(issue_ok), 32'(i < 3));
        end
        mul_start = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            drive_done(tbl[i].in_r, tbl[i].in_inf, tbl[i].in_zero, 1'b1);
            tick();
            check("fill_count",    32'(count),    32'(i + 1));
            check("fill_issue_ok", 32'(issue_ok), 32'(0));
        end
        clear_done();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tbl_data", 32'(out_data), 32'(tbl[i].exp_data));
            check("tbl_inf",  32'(out_inf),  32'(tbl[i].exp_inf));
            check("tbl_zero", 32'(out_zero), 32'(tbl[i].exp_zero));
            tick();
            if (i == 0) check("drain_issue_ok", 32'(issue_ok), 32'(1));
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'(0));
        check("drain_err",   32'(err),   32'(0));

        // ---- simultaneous read/write at full, then overflow
        for (int i = 0; i < 4; i++) begin
            mul_start = 1'b1;
            tick();
        end
        mul_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_done(16'h6000 + 16'(i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        clear_done();
        check("full_count", 32'(count), 32'(4));
        // At full no operation can legally be in flight. This done therefore
        // also flags a stray done, and err is not examined until the overflow.
        drive_done(16'h7777, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        clear_done();
        out_ready = 1'b0;
        check("rw_full_count", 32'(count),    32'(4));
        check("rw_full_head",  32'(out_data), 32'(16'h6001));
        drive_done(16'h7fff, 1'b0, 1'b0, 1'b0);
        tick();
        clear_done();
        check("ovf_count", 32'(count),    32'(4));
        check("ovf_err",   32'(err),      32'(1));
        check("ovf_head",  32'(out_data), 32'(16'h6001));
        drain(10);
        check("ovf_drained", 32'(sb.size()), 32'(0));

        // ---- reset, then a done with nothing in flight
        do_reset();
        check("rst2_err",   32'(err),   32'(0));
        check("rst2_count", 32'(count), 32'(0));
        drive_done(16'h1234, 1'b0, 1'b0, 1'b1);
        tick();
        clear_done();
        check("udf_err",   32'(err),   32'(1));
        check("udf_count", 32'(count), 32'(1));
        drain(4);
        for (int i = 0; i < 4; i++) begin
            mul_start = 1'b1;
            tick();
            check("udf_inflight", 32'(issue_ok), 32'(i < 3));
        end
        mul_start = 1'b0;
        do_reset();
        check("rst3_issue_ok", 32'(issue_ok), 32'(1));
        check("rst3_err",      32'(err),      32'(0));

        // ---- backpressure: 20 results, 3-cycle pipelined multiplier
        n_rx   = 0;
        issued = 0;
        cyc    = 0;
        while ((n_rx < 20 || pend.size() != 0) && cyc < 600) begin
            out_ready = 1'($urandom_range(0, 1));
            if (pend.size() != 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                rr = 16'($urandom);
                drive_done(rr, 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0), 1'b1);
            end else begin
                clear_done();
            end
            if (issue_ok && issued < 20) begin
                mul_start = 1'b1;
                pend.push_back(cyc + 3);
                issued++;
            end else begin
                mul_start = 1'b0;
            end
            tick();
            cyc++;
        end
        clear_done();
        mul_start = 1'b0;
        out_ready = 1'b0;
        check("bp_received",  32'(n_rx),      32'(20));
        check("bp_sb_empty",  32'(sb.size()), 32'(0));
        check("bp_err",       32'(err),       32'(0));
        check("bp_count",     32'(count),     32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
